dpram_copy_engine: RTL

DPRAM_COPY_ENGINE -- requirements
Module: dpram_copy_engine

---
 rtl/dpram_pkg.sv | 16 +
 rtl/dpram_copy_engine_if.sv | 32 +++
 rtl/dpram_copy_addr_gen.sv | 40 ++++
 rtl/dpram_copy_engine.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/dpram_pkg.sv
// Shared definitions for the dual-port RAM copy engine: default widths,
// maximum copy length and the controller state encoding.
package dpram_pkg;

    localparam int AW_DEF  = 10;
    localparam int DW_DEF  = 16;
    localparam int MAX_LEN = 1024;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } copy_state_t;

endpackage

// File: rtl/dpram_copy_engine_if.sv
// Command/status and RAM port signals of the copy engine. The master side is the
// system (command source plus RAM), the slave side is the engine itself.
interface dpram_copy_engine_if #(
    parameter int AW = dpram_pkg::AW_DEF,
    parameter int DW = dpram_pkg::DW_DEF
) ();

    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic          err;
    logic          re_p1;
    logic [AW-1:0] add_read_p1;
    logic [DW-1:0] output_data_p1;
    logic          we_p2;
    logic [AW-1:0] add_write_p2;
    logic [DW-1:0] input_data_p2;

    modport master (
        output start, src_addr, dst_addr, len, output_data_p1,
        input  busy, done, err, re_p1, add_read_p1, we_p2, add_write_p2, input_data_p2
    );

    modport slave (
        input  start, src_addr, dst_addr, len, output_data_p1,
        output busy, done, err, re_p1, add_read_p1, we_p2, add_write_p2, input_data_p2
    );

endinterface

// File: rtl/dpram_copy_addr_gen.sv
// Wrapping up/down word-address counter with synchronous load; load wins over step.
module dpram_copy_addr_gen #(
    parameter int AW = dpram_pkg::AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          step_i,
    input  logic          down_i,
    output logic [AW-1:0] addr_o
);

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_d;

    // next address: load, step up/down with natural modulo-2^AW wrap, or hold
    always_comb begin
        addr_d = addr_q;
        if (load_i) begin
            addr_d = load_val_i;
        end else if (step_i) begin
            addr_d = down_i ? (addr_q - AW'(1'b1)) : (addr_q + AW'(1'b1));
        end else begin
            addr_d = addr_q;
        end
    end

    // address register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= {AW{1'b0}};
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;

endmodule

// File: rtl/dpram_copy_engine.sv
// Block copy between two ports of a dual-port RAM: reads on port 1, writes on port 2,
// one word per cycle, direction chosen so that overlapping regions copy correctly.
module dpram_copy_engine
    import dpram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input logic                clk,
    input logic                rst,
    dpram_copy_engine_if.slave bus
);

    localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LEN_ONE = {{AW{1'b0}}, 1'b1};

    copy_state_t   state_q, state_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          desc_q, desc_d;
    logic          err_q, err_d;
    logic          we_q, we_d;

    logic          accept_s;
    logic          len_ok_s;
    logic [AW-1:0] diff_s;
    logic [AW:0]   len_m1_s;
    logic [AW-1:0] span_s;
    logic          desc_s;
    logic [AW-1:0] src_start_s;
    logic [AW-1:0] dst_start_s;
    logic [AW-1:0] src_addr_s;
    logic [AW-1:0] dst_addr_s;

    // command decode: a copy runs downward only when the destination starts inside the source span
    always_comb begin
        accept_s    = (state_q == IDLE) && bus.start;
        len_ok_s    = (bus.len != {(AW+1){1'b0}}) && (bus.len <= LEN_MAX);
        diff_s      = bus.dst_addr - bus.src_addr;
        len_m1_s    = bus.len - LEN_ONE;
        span_s      = len_m1_s[AW-1:0];
        desc_s      = (diff_s != {AW{1'b0}}) && ({1'b0, diff_s} < bus.len);
        src_start_s = desc_s ? (bus.src_addr + span_s) : bus.src_addr;
        dst_start_s = desc_s ? (bus.dst_addr + span_s) : bus.dst_addr;
    end

    dpram_copy_addr_gen #(.AW(AW)) u_src_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s),
        .load_val_i (src_start_s),
        .step_i     (state_q == RUN),
        .down_i     (desc_q),
        .addr_o     (src_addr_s)
    );

    // the destination counter advances on each write, so it trails the source by one cycle
    dpram_copy_addr_gen #(.AW(AW)) u_dst_gen (
        .clk        (clk),
        .rst        (rst),
        .load_i     (accept_s),
        .load_val_i (dst_start_s),
        .step_i     (we_q),
        .down_i     (desc_q),
        .addr_o     (dst_addr_s)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = len_ok_s ? RUN : DONE;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == LEN_ONE) begin
                    state_d = DRAIN;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values: remaining-read count, direction, error flag, write strobe
    always_comb begin
        cnt_d  = cnt_q;
        desc_d = desc_q;
        err_d  = err_q;
        we_d   = (state_q == RUN);
        if (accept_s) begin
            cnt_d  = bus.len;
            desc_d = desc_s;
            err_d  = (bus.len > LEN_MAX);
        end else if (state_q == RUN) begin
            cnt_d  = cnt_q - LEN_ONE;
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {(AW+1){1'b0}};
            desc_q <= 1'b0;
            err_q  <= 1'b0;
            we_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            desc_q <= desc_d;
            err_q  <= err_d;
            we_q   <= we_d;
        end
    end

    // outputs decoded from registered state; write data passes straight from the read port
    always_comb begin
        bus.busy          = (state_q != IDLE);
        bus.done          = (state_q == DONE);
        bus.err           = (state_q == DONE) && err_q;
        bus.re_p1         = (state_q == RUN);
        bus.add_read_p1   = src_addr_s;
        bus.we_p2         = we_q;
        bus.add_write_p2  = dst_addr_s;
        bus.input_data_p2 = bus.output_data_p1;
    end

endmodule
